// File: rtl/gtp_tx_framer.sv
// Transmit-side link framer for a GTP TX path with 8b10b enabled.
// Wraps each upstream packet as SOF, payload, checksum, EOF and fills the
// link with comma idles between frames. Single clock domain (tx_clk).
//
// Handshake: a payload word transfers on a rising tx_clk edge where
// s_valid and s_ready are both high. s_ready is combinational
// (state==DATA && link_ready), so it never depends on s_valid.
// s_data and s_last are only looked at when s_valid is high.
module gtp_tx_framer #(
  parameter int MAX_LEN  = 256,
  parameter int IDLE_MIN = 4
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        link_ready,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] tx_data,
  output logic        tx_is_k,
  output logic [15:0] frame_count,
  output logic        trunc,
  output logic        abort,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2,
    ST_EOF  = 2'd3
  } state_t;

  localparam logic [15:0] W_IDLE   = 16'h50BC;  // D16.2 / K28.5 comma
  localparam logic [15:0] W_SOF    = 16'h55FB;  // K27.7
  localparam logic [15:0] W_EOF    = 16'h55FD;  // K29.7
  localparam logic [15:0] W_FILL   = 16'h55F7;  // K23.7, dropped by receiver
  localparam logic [7:0]  IDLE_TGT = 8'(IDLE_MIN);
  localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  idle_cnt, idle_cnt_nxt;
  logic [15:0] csum, csum_nxt;
  logic [15:0] len, len_nxt;
  logic [15:0] len_inc;
  logic [15:0] tx_data_nxt;
  logic        tx_is_k_nxt;
  logic [15:0] frame_count_nxt;
  logic        trunc_nxt;
  logic        abort_nxt;

  assign len_inc   = len + 16'd1;
  assign dbg_state = state;

  // State and output registers; every output word is registered.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idle_cnt    <= 8'd0;
      csum        <= 16'd0;
      len         <= 16'd0;
      tx_data     <= W_IDLE;
      tx_is_k     <= 1'b1;
      frame_count <= 16'd0;
      trunc       <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_nxt;
      idle_cnt    <= idle_cnt_nxt;
      csum        <= csum_nxt;
      len         <= len_nxt;
      tx_data     <= tx_data_nxt;
      tx_is_k     <= tx_is_k_nxt;
      frame_count <= frame_count_nxt;
      trunc       <= trunc_nxt;
      abort       <= abort_nxt;
    end
  end

  // Next-state, next output word and source backpressure.
  always_comb begin
    state_nxt       = state;
    idle_cnt_nxt    = idle_cnt;
    csum_nxt        = csum;
    len_nxt         = len;
    tx_data_nxt     = W_IDLE;
    tx_is_k_nxt     = 1'b1;
    frame_count_nxt = frame_count;
    trunc_nxt       = 1'b0;
    abort_nxt       = 1'b0;
    s_ready         = (state == ST_DATA) && link_ready;

    case (state)
      ST_IDLE: begin
        // Idles only count while the link is up, so the far end always sees
        // at least IDLE_MIN commas before a SOF.
        if ((idle_cnt == IDLE_TGT) && link_ready && s_valid) begin
          tx_data_nxt = W_SOF;
          csum_nxt    = 16'd0;
          len_nxt     = 16'd0;
          state_nxt   = ST_DATA;
        end else if (link_ready && (idle_cnt != IDLE_TGT)) begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end

      ST_DATA: begin
        if (!link_ready) begin
          abort_nxt    = 1'b1;
          idle_cnt_nxt = 8'd0;
          state_nxt    = ST_IDLE;
        end else if (s_valid) begin
          tx_data_nxt = s_data;
          tx_is_k_nxt = 1'b0;
          csum_nxt    = csum + s_data;
          len_nxt     = len_inc;
          if (s_last || (len_inc == LEN_MAX)) begin
            state_nxt = ST_CSUM;
          end
          // A packet that ends exactly at MAX_LEN closes normally.
          trunc_nxt = !s_last && (len_inc == LEN_MAX);
        end else begin
          tx_data_nxt = W_FILL;
        end
      end

      ST_CSUM: begin
        if (!link_ready) begin
          abort_nxt    = 1'b1;
          idle_cnt_nxt = 8'd0;
          state_nxt    = ST_IDLE;
        end else begin
          tx_data_nxt = csum;
          tx_is_k_nxt = 1'b0;
          state_nxt   = ST_EOF;
        end
      end

      ST_EOF: begin
        if (!link_ready) begin
          abort_nxt    = 1'b1;
          idle_cnt_nxt = 8'd0;
          state_nxt    = ST_IDLE;
        end else begin
          tx_data_nxt     = W_EOF;
          frame_count_nxt = frame_count + 16'd1;
          idle_cnt_nxt    = 8'd0;
          state_nxt       = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer: per-cycle vector tables for the directed cases,
// a hand-written mid-frame reset, then randomized packets checked against a
// packet-level frame model.
module tb_gtp_tx_framer;

  localparam int MAX_LEN  = 4;
  localparam int IDLE_MIN = 4;

  localparam logic [15:0] K_IDLE = 16'h50BC;
  localparam logic [15:0] K_SOF  = 16'h55FB;
  localparam logic [15:0] K_EOF  = 16'h55FD;
  localparam logic [15:0] K_FILL = 16'h55F7;

  // ---------------- clock / reset / DUT ----------------
  logic        tx_clk = 1'b0;
  logic        reset = 1'b1;
  logic        link_ready = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] tx_data;
  logic        tx_is_k;
  logic [15:0] frame_count;
  logic        trunc;
  logic        abort;
  logic [1:0]  dbg_state;

  always #5 tx_clk = ~tx_clk;

  gtp_tx_framer #(.MAX_LEN(MAX_LEN), .IDLE_MIN(IDLE_MIN)) dut (
    .tx_clk(tx_clk),
    .reset(reset),
    .link_ready(link_ready),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .tx_data(tx_data),
    .tx_is_k(tx_is_k),
    .frame_count(frame_count),
    .trunc(trunc),
    .abort(abort),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        lr;
    logic        v;
    logic [15:0] d;
    logic        last;
    logic        er;    // s_ready before the edge
    logic [15:0] ed;    // tx_data after the edge
    logic        ek;
    logic        et;
    logic        ea;
    logic [15:0] efc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic lr, input logic v, input logic [15:0] d,
                              input logic last, input logic er, input logic [15:0] ed,
                              input logic ek, input logic et, input logic ea,
                              input logic [15:0] efc);
    vec_t r;
    r.lr = lr; r.v = v; r.d = d; r.last = last; r.er = er;
    r.ed = ed; r.ek = ek; r.et = et; r.ea = ea; r.efc = efc;
    vq.push_back(r);
  endfunction

  // Apply each row for one clock and compare outputs just after the edge.
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      vec_t r;
      r = vq[i];
      link_ready = r.lr;
      s_valid    = r.v;
      s_data     = r.d;
      s_last     = r.last;
      #1;
      check($sformatf("%s[%0d].s_ready", tag, i), s_ready, r.er);
      @(posedge tx_clk);
      #1;
      check($sformatf("%s[%0d].word", tag, i), {tx_is_k, tx_data}, {r.ek, r.ed});
      check($sformatf("%s[%0d].trunc", tag, i), trunc, r.et);
      check($sformatf("%s[%0d].abort", tag, i), abort, r.ea);
      check($sformatf("%s[%0d].frame_count", tag, i), frame_count, r.efc);
    end
    vq.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset      = 1'b1;
    link_ready = 1'b1;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_data     = 16'd0;
    @(posedge tx_clk);
    #1;
    check("reset.word", {tx_is_k, tx_data}, {1'b1, K_IDLE});
    check("reset.s_ready", s_ready, 1'b0);
    check("reset.frame_count", frame_count, 16'd0);
    check("reset.pulses", {trunc, abort}, 2'b00);
    @(posedge tx_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add_idles(input int n, input logic lr, input logic v, input logic [15:0] d,
                           input logic last, input logic [15:0] fc);
    for (int i = 0; i < n; i++) add(lr, v, d, last, 1'b0, K_IDLE, 1'b1, 1'b0, 1'b0, fc);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [16:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          gap = 0;
  int          trunc_seen = 0;
  int          exp_trunc = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [16:0] mon_word;
  logic [16:0] mon_exp;

  // Expected framing of one packet: split into MAX_LEN-word chunks, each sent
  // as SOF, payload, 16-bit sum of the payload, EOF. Every chunk but the last
  // is force-closed and flagged with trunc.
  task automatic model_packet(input logic [15:0] pkt[$]);
    int L;
    L = pkt.size();
    for (int base = 0; base < L; base += MAX_LEN) begin
      int n;
      logic [15:0] sum;
      n = (L - base < MAX_LEN) ? (L - base) : MAX_LEN;
      sum = 16'd0;
      exp_q.push_back({1'b1, K_SOF});
      for (int j = 0; j < n; j++) begin
        exp_q.push_back({1'b0, pkt[base + j]});
        sum = sum + pkt[base + j];
      end
      exp_q.push_back({1'b0, sum});
      exp_q.push_back({1'b1, K_EOF});
      exp_frames = exp_frames + 16'd1;
      if (base + n < L) exp_trunc++;
    end
  endtask

  // Monitor: drop idles and fills, compare every other word in order, and
  // make sure each SOF follows at least IDLE_MIN idles.
  always @(negedge tx_clk) begin
    if (mon_en) begin
      mon_word = {tx_is_k, tx_data};
      if (trunc) begin
        trunc_seen++;
        check("rand.trunc_on_payload", tx_is_k, 1'b0);
      end
      check("rand.no_abort", abort, 1'b0);
      if (mon_word == {1'b1, K_IDLE}) begin
        gap++;
      end else begin
        if (mon_word == {1'b1, K_SOF}) check("rand.idle_gap", (gap >= IDLE_MIN), 1'b1);
        if (mon_word != {1'b1, K_FILL}) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rand.unexpected_word actual=%h required=none", mon_word);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rand.stream", mon_word, mon_exp);
          end
        end
        gap = 0;
      end
    end
  end

  task automatic send_packet(input logic [15:0] pkt[$]);
    for (int j = 0; j < pkt.size(); j++) begin
      bit acc;
      int budget;
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge tx_clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = pkt[j];
      s_last  = (j == pkt.size() - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 60) begin
        @(negedge tx_clk);
        acc = s_ready;
        @(posedge tx_clk);
        #1;
        budget++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL rand.accept_timeout actual=no_handshake required=handshake");
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset and basic 3-word frame, then idles.
    do_reset();
    add_idles(4, 1, 1, 16'h1111, 0, 16'd0);
    add(1, 1, 16'h1111, 0, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'h1111, 0, 1, 16'h1111, 0, 0, 0, 16'd0);
    add(1, 1, 16'h2222, 0, 1, 16'h2222, 0, 0, 0, 16'd0);
    add(1, 1, 16'h3333, 1, 1, 16'h3333, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, 16'h6666, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, K_EOF,    1, 0, 0, 16'd1);
    add_idles(4, 1, 0, 16'h0000, 0, 16'd1);
    run_table("basic");

    // Idle count held while link is down, then a 2-cycle source gap.
    do_reset();
    add_idles(1, 1, 1, 16'h0101, 0, 16'd0);
    add_idles(2, 0, 1, 16'h0101, 0, 16'd0);
    add_idles(3, 1, 1, 16'h0101, 0, 16'd0);
    add(1, 1, 16'h0101, 0, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'h0101, 0, 1, 16'h0101, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 1, K_FILL,   1, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 1, K_FILL,   1, 0, 0, 16'd0);
    add(1, 1, 16'h0202, 1, 1, 16'h0202, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, 16'h0303, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, K_EOF,    1, 0, 0, 16'd1);
    run_table("gap");

    // 6-word packet split at MAX_LEN=4.
    do_reset();
    add_idles(4, 1, 1, 16'h1000, 0, 16'd0);
    add(1, 1, 16'h1000, 0, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'h1000, 0, 1, 16'h1000, 0, 0, 0, 16'd0);
    add(1, 1, 16'h2000, 0, 1, 16'h2000, 0, 0, 0, 16'd0);
    add(1, 1, 16'h3000, 0, 1, 16'h3000, 0, 0, 0, 16'd0);
    add(1, 1, 16'h4000, 0, 1, 16'h4000, 0, 1, 0, 16'd0);
    add(1, 1, 16'h5000, 0, 0, 16'hA000, 0, 0, 0, 16'd0);
    add(1, 1, 16'h5000, 0, 0, K_EOF,    1, 0, 0, 16'd1);
    add_idles(4, 1, 1, 16'h5000, 0, 16'd1);
    add(1, 1, 16'h5000, 0, 0, K_SOF,    1, 0, 0, 16'd1);
    add(1, 1, 16'h5000, 0, 1, 16'h5000, 0, 0, 0, 16'd1);
    add(1, 1, 16'h6000, 1, 1, 16'h6000, 0, 0, 0, 16'd1);
    add(1, 0, 16'h0000, 0, 0, 16'hB000, 0, 0, 0, 16'd1);
    add(1, 0, 16'h0000, 0, 0, K_EOF,    1, 0, 0, 16'd2);
    run_table("trunc");

    // Link drop mid-payload, recovery, then a drop in the checksum slot.
    do_reset();
    add_idles(4, 1, 1, 16'h0A0A, 0, 16'd0);
    add(1, 1, 16'h0A0A, 0, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'h0A0A, 0, 1, 16'h0A0A, 0, 0, 0, 16'd0);
    add(0, 1, 16'h0B0B, 0, 0, K_IDLE,   1, 0, 1, 16'd0);
    add_idles(2, 0, 1, 16'h0B0B, 0, 16'd0);
    add_idles(4, 1, 1, 16'h0C0C, 1, 16'd0);
    add(1, 1, 16'h0C0C, 1, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'h0C0C, 1, 1, 16'h0C0C, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, 16'h0C0C, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, K_EOF,    1, 0, 0, 16'd1);
    add_idles(4, 1, 1, 16'h0D0D, 1, 16'd1);
    add(1, 1, 16'h0D0D, 1, 0, K_SOF,    1, 0, 0, 16'd1);
    add(1, 1, 16'h0D0D, 1, 1, 16'h0D0D, 0, 0, 0, 16'd1);
    add(0, 0, 16'h0000, 0, 0, K_IDLE,   1, 0, 1, 16'd1);
    run_table("abort");

    // Checksum wrap, then a reset in the middle of the next frame.
    do_reset();
    add_idles(4, 1, 1, 16'hFFFF, 0, 16'd0);
    add(1, 1, 16'hFFFF, 0, 0, K_SOF,    1, 0, 0, 16'd0);
    add(1, 1, 16'hFFFF, 0, 1, 16'hFFFF, 0, 0, 0, 16'd0);
    add(1, 1, 16'h0002, 1, 1, 16'h0002, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, 0, 16'd0);
    add(1, 0, 16'h0000, 0, 0, K_EOF,    1, 0, 0, 16'd1);
    add_idles(4, 1, 1, 16'h1234, 0, 16'd1);
    add(1, 1, 16'h1234, 0, 0, K_SOF,    1, 0, 0, 16'd1);
    add(1, 1, 16'h1234, 0, 1, 16'h1234, 0, 0, 0, 16'd1);
    run_table("wrap");
    #2;
    reset = 1'b1;
    #1;
    check("midreset.word", {tx_is_k, tx_data}, {1'b1, K_IDLE});
    check("midreset.s_ready", s_ready, 1'b0);
    check("midreset.frame_count", frame_count, 16'd0);
    check("midreset.state", dbg_state, 2'd0);

    // Randomized packets with source gaps, link held up.
    do_reset();
    gap = 0;
    mon_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [15:0] pkt[$];
      int L;
      L = $urandom_range(1, 9);
      for (int j = 0; j < L; j++) pkt.push_back(16'($urandom));
      model_packet(pkt);
      send_packet(pkt);
      repeat ($urandom_range(0, 5)) @(posedge tx_clk);
      #1;
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge tx_clk);
    repeat (3) @(posedge tx_clk);
    #1;
    mon_en = 1'b0;
    check("rand.drained", exp_q.size(), 0);
    check("rand.frame_count", frame_count, exp_frames);
    check("rand.trunc_count", trunc_seen, exp_trunc);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
